psram_opi_resp: RTL and testbench
=================================

PSRAM_OPI_RESP -- requirements
Module: psram_opi_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory size in bytes (power of two, 16..4096).
REQ-002 SHALL have parameter WCMD, default 8'h80, meaning the linear-burst write opcode.
REQ-003 SHALL have parameter RCMD, default 8'h00, meaning the linear-burst read opcode.
REQ-004 SHALL have parameter RLC, default 5, meaning read latency in sck cycles (1..15).
REQ-005 SHALL have parameter WLC, default 5, meaning write latency in sck cycles (1..15).
REQ-006 SHALL have ports:
- clk_i  in  1  single system clock; all flops on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- psram_sck_i  in  1  serial clock from the controller.
- psram_ce_i  in  1  chip enable, active low.
- psram_io_in_i  in  8  OPI data/command/address input.
- psram_io_out_o  out  8  read data.
- psram_io_en_o  out  8  per-bit output enable.
- psram_dqs_in_i  in  1  write data mask; high masks the byte.
- psram_dqs_out_o  out  1  read strobe.
- psram_dqs_en_o  out  1  strobe output enable.
- busy_o  out  1  transaction in progress.
- err_o  out  1  sticky flag for an unknown opcode.

Function
REQ-007 SHALL pass psram_sck_i, psram_ce_i, psram_io_in_i and psram_dqs_in_i through identical 2-flop synchronizers, so the inputs stay aligned.
REQ-008 SHALL detect sck edges from the synchronized sck (current vs. previous) and act only on the clk_i cycle of a detected edge.
REQ-009 SHALL support sck half-periods of at least 4 clk_i cycles (controller PSCR DIV8 or slower).
REQ-010 SHALL use an FSM with states IDLE, INST, ADDR, LATN, WDATA and RDATA.
REQ-011 SHALL move from IDLE to INST when synchronized ce falls.
REQ-012 INST SHALL capture io on the first sck rising edge as the opcode, ignore the falling edge, then enter ADDR.
REQ-013 ADDR SHALL capture 4 address bytes, MSB first, on the next 4 sck edges (rise, fall, rise, fall).
REQ-014 The address SHALL be taken as address[log2(DEPTH)-1:1] with bit 0 forced to 0, giving an even start.
REQ-015 At the end of ADDR, an opcode equal to WCMD or RCMD SHALL load the latency counter with WLC or RLC and enter LATN.
REQ-016 Any other opcode SHALL set err_o and return to IDLE, ignoring the rest of the transaction until ce rises.
REQ-017 LATN SHALL decrement the counter on each sck rising edge and, on reaching 0, enter WDATA or RDATA.
REQ-018 WDATA SHALL, on every sck edge, write io to mem[addr] unless dqs_in is high, then increment addr.
REQ-019 RDATA SHALL, on entry, drive io_out = mem[addr], io_en = 8'hFF, dqs_en = 1 and dqs_out = 0.
REQ-020 RDATA SHALL, on every subsequent sck edge, increment addr, drive mem[addr] and toggle dqs_out.
REQ-021 The address SHALL wrap modulo DEPTH, with no limit on burst length.
REQ-022 A synchronized ce rise in any state SHALL return the FSM to IDLE the next cycle, deassert io_en and dqs_en, and keep bytes already written.
REQ-023 A ce rise SHALL take priority over an sck edge detected in the same cycle.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 io_en and dqs_en SHALL be 0 in every state except RDATA.
REQ-026 err_o SHALL be cleared only by reset.

Reset
REQ-027 On rst_i SHALL set: FSM to IDLE; psram_io_out_o = 0; psram_io_en_o = 0; psram_dqs_out_o = 0; psram_dqs_en_o = 0; busy_o = 0; err_o = 0; synchronizers to sck = 0, ce = 1.
REQ-028 Reset SHALL NOT clear memory contents; reset asserted mid-transaction SHALL abort the transaction immediately.

Structure
REQ-029 SHALL reuse the shared PSRAM define file for the FSM state encodings (PSRAM_FSM_*) and the psram_if tb modport signal set.
REQ-030 SHALL place the opcode defaults and the latency bounds in that same shared file.
REQ-031 SHALL implement the synchronizer and edge detector as sub-module psram_sync_edge, instantiated once.
REQ-032 The memory SHALL be an inferred register array.

Verification
REQ-033 Write then read: write opcode 8'h80, addr 0x00000010, WLC = 5, bytes A5,5A,3C,C3, then read opcode 8'h00 at 0x10 -> io_out returns A5,5A,3C,C3 on successive dqs edges.
REQ-034 Odd address: write 11,22 at address 0x21 -> data lands at 0x20,0x21; a read of 0x20 returns 11,22.
REQ-035 Wrap-around: write 4 bytes at 0xFE with DEPTH = 256 -> mem[0xFE], mem[0xFF], mem[0x00], mem[0x01] are written.
REQ-036 Mask: write AA,BB,CC with dqs_in high on the second byte -> the second location keeps its old value.
REQ-037 Bad opcode: opcode 8'h40 -> err_o = 1, io_en stays 0, and a following valid read succeeds.
REQ-038 Abort: ce rises after 2 read data edges, and separately rst_i pulses in LATN -> next cycle busy_o = 0, io_en = 0, dqs_en = 0.

Source files
------------

// File: rtl/psram_opi_resp_pkg.sv
// Shared PSRAM definitions: FSM state encodings, default opcodes and
// the legal bounds for memory depth and access latency.
package psram_opi_resp_pkg;

    typedef enum logic [2:0] {
        PSRAM_FSM_IDLE  = 3'd0,
        PSRAM_FSM_INST  = 3'd1,
        PSRAM_FSM_ADDR  = 3'd2,
        PSRAM_FSM_LATN  = 3'd3,
        PSRAM_FSM_WDATA = 3'd4,
        PSRAM_FSM_RDATA = 3'd5
    } psram_fsm_e;

    localparam logic [7:0] PSRAM_WCMD_DEF = 8'h80;
    localparam logic [7:0] PSRAM_RCMD_DEF = 8'h00;

    localparam int PSRAM_LAT_MIN   = 1;
    localparam int PSRAM_LAT_MAX   = 15;
    localparam int PSRAM_DEPTH_MIN = 16;
    localparam int PSRAM_DEPTH_MAX = 4096;

endpackage

// File: rtl/psram_sync_edge.sv
// Two-flop synchronizer for the whole OPI bus plus sck/ce edge detection.
// All inputs share one pipeline so data stays aligned with the clock edges.
module psram_sync_edge (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       ce_i,
    input  logic [7:0] io_i,
    input  logic       dqs_i,
    output logic [7:0] io_o,
    output logic       dqs_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       ce_rise_o,
    output logic       ce_fall_o
);

    // bit layout: {sck, ce, dqs, io[7:0]}; ce idles high, everything else low
    localparam logic [10:0] SYNC_RST = {1'b0, 1'b1, 1'b0, 8'h00};

    logic [10:0] s1_q, s2_q;
    logic        sck_prev_q, ce_prev_q;

    // synchronizer stages and previous-value flops for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q       <= SYNC_RST;
            s2_q       <= SYNC_RST;
            sck_prev_q <= 1'b0;
            ce_prev_q  <= 1'b1;
        end else begin
            s1_q       <= {sck_i, ce_i, dqs_i, io_i};
            s2_q       <= s1_q;
            sck_prev_q <= s2_q[10];
            ce_prev_q  <= s2_q[9];
        end
    end

    assign io_o       = s2_q[7:0];
    assign dqs_o      = s2_q[8];
    assign sck_rise_o =  s2_q[10] & ~sck_prev_q;
    assign sck_fall_o = ~s2_q[10] &  sck_prev_q;
    assign ce_rise_o  =  s2_q[9]  & ~ce_prev_q;
    assign ce_fall_o  = ~s2_q[9]  &  ce_prev_q;

endmodule

// File: rtl/psram_opi_resp.sv
// Octal-SPI PSRAM responder: decodes opcode/address from the controller,
// waits the configured latency, then streams DDR write or read data
// against an internal byte array.
module psram_opi_resp
    import psram_opi_resp_pkg::*;
#(
    parameter int         DEPTH = 256,
    parameter logic [7:0] WCMD  = PSRAM_WCMD_DEF,
    parameter logic [7:0] RCMD  = PSRAM_RCMD_DEF,
    parameter int         RLC   = 5,
    parameter int         WLC   = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_in_i,
    output logic [7:0] psram_io_out_o,
    output logic [7:0] psram_io_en_o,
    input  logic       psram_dqs_in_i,
    output logic       psram_dqs_out_o,
    output logic       psram_dqs_en_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    io_s;
    logic          dqs_s, sck_rise, sck_fall, sck_edge, ce_rise, ce_fall;

    psram_fsm_e    state_q;
    logic [7:0]    opcode_q;
    logic [23:0]   addr_q;
    logic [1:0]    bcnt_q;
    logic [3:0]    lat_q;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    io_out_q, io_en_q;
    logic          dqs_out_q, dqs_en_q, err_q;

    logic [31:0]   addr_full;
    logic [AW-1:0] start_ptr;
    logic          mem_we;
    logic          unused_addr;

    logic [7:0]    mem_q [DEPTH];

    psram_sync_edge u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (psram_sck_i),
        .ce_i       (psram_ce_i),
        .io_i       (psram_io_in_i),
        .dqs_i      (psram_dqs_in_i),
        .io_o       (io_s),
        .dqs_o      (dqs_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ce_rise_o  (ce_rise),
        .ce_fall_o  (ce_fall)
    );

    assign sck_edge  = sck_rise | sck_fall;
    // last address byte arrives with the edge that ends ADDR
    assign addr_full = {addr_q, io_s};
    // start is always even: bit 0 of the incoming address is dropped
    assign start_ptr = {addr_full[AW-1:1], 1'b0};
    assign ptr_d     = ptr_q + AW'(1);
    assign unused_addr = ^{addr_full[31:AW], addr_full[0]};

    // a ce rise on the same cycle wins, so no write can slip in behind it
    assign mem_we = (state_q == PSRAM_FSM_WDATA) && sck_edge && !ce_rise && !dqs_s;

    // byte array; deliberately not reset so contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[ptr_q] <= io_s;
    end

    // transaction FSM with registered pad controls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= PSRAM_FSM_IDLE;
            opcode_q  <= 8'h00;
            addr_q    <= 24'h0;
            bcnt_q    <= 2'd0;
            lat_q     <= 4'd0;
            ptr_q     <= '0;
            io_out_q  <= 8'h00;
            io_en_q   <= 8'h00;
            dqs_out_q <= 1'b0;
            dqs_en_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (ce_rise) begin
            state_q   <= PSRAM_FSM_IDLE;
            io_en_q   <= 8'h00;
            dqs_en_q  <= 1'b0;
            dqs_out_q <= 1'b0;
        end else begin
            case (state_q)
                PSRAM_FSM_IDLE: begin
                    if (ce_fall) begin
                        state_q <= PSRAM_FSM_INST;
                        bcnt_q  <= 2'd0;
                    end
                end
                // opcode on the rise; the following fall just closes INST
                PSRAM_FSM_INST: begin
                    if (sck_rise) begin
                        opcode_q <= io_s;
                        bcnt_q   <= 2'd1;
                    end else if (sck_fall && bcnt_q == 2'd1) begin
                        state_q <= PSRAM_FSM_ADDR;
                        bcnt_q  <= 2'd0;
                    end
                end
                PSRAM_FSM_ADDR: begin
                    if (sck_edge) begin
                        addr_q <= addr_full[23:0];
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            ptr_q <= start_ptr;
                            if (opcode_q == WCMD) begin
                                lat_q   <= 4'(WLC);
                                state_q <= PSRAM_FSM_LATN;
                            end else if (opcode_q == RCMD) begin
                                lat_q   <= 4'(RLC);
                                state_q <= PSRAM_FSM_LATN;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= PSRAM_FSM_IDLE;
                            end
                        end
                    end
                end
                PSRAM_FSM_LATN: begin
                    if (sck_rise) begin
                        lat_q <= lat_q - 4'd1;
                        if (lat_q == 4'd1) begin
                            if (opcode_q == WCMD) begin
                                state_q <= PSRAM_FSM_WDATA;
                            end else begin
                                state_q   <= PSRAM_FSM_RDATA;
                                io_out_q  <= mem_q[ptr_q];
                                io_en_q   <= 8'hFF;
                                dqs_en_q  <= 1'b1;
                                dqs_out_q <= 1'b0;
                            end
                        end
                    end
                end
                PSRAM_FSM_WDATA: begin
                    if (sck_edge) ptr_q <= ptr_d;
                end
                PSRAM_FSM_RDATA: begin
                    if (sck_edge) begin
                        ptr_q     <= ptr_d;
                        io_out_q  <= mem_q[ptr_d];
                        dqs_out_q <= ~dqs_out_q;
                    end
                end
                default: state_q <= PSRAM_FSM_IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != PSRAM_FSM_IDLE);
    assign err_o           = err_q;
    assign psram_io_out_o  = io_out_q;
    assign psram_io_en_o   = io_en_q;
    assign psram_dqs_out_o = dqs_out_q;
    assign psram_dqs_en_o  = dqs_en_q;

endmodule

// File: tb/tb_psram_opi_resp.sv
// Bench for psram_opi_resp: drives OPI transactions with sck half-period
// of 8 clk cycles, keeps a byte model of the memory, and scoreboards reads.
module tb_psram_opi_resp;

    localparam int Q   = 4;
    localparam int LAT = 5;

    logic       clk = 1'b0, rst = 1'b1, sck = 1'b0, ce = 1'b1, dqs_in = 1'b0;
    logic [7:0] io_in = 8'h00;
    logic [7:0] io_out, io_en;
    logic       dqs_out, dqs_en, busy, err;

    int n_cmp = 0, n_bad = 0;
    logic [7:0]  tb_mem [256];
    logic [7:0]  exp_q [$];
    logic [17:0] got_q [$];

    psram_opi_resp #(.DEPTH(256), .WCMD(8'h80), .RCMD(8'h00), .RLC(LAT), .WLC(LAT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .psram_sck_i     (sck),
        .psram_ce_i      (ce),
        .psram_io_in_i   (io_in),
        .psram_io_out_o  (io_out),
        .psram_io_en_o   (io_en),
        .psram_dqs_in_i  (dqs_in),
        .psram_dqs_out_o (dqs_out),
        .psram_dqs_en_o  (dqs_en),
        .busy_o          (busy),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_tog(input logic [7:0] v, input logic m);
        io_in = v; dqs_in = m;
        clks(Q);
        sck = ~sck;
        clks(Q);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [31:0] a);
        ce = 1'b0;
        clks(Q);
        sck_tog(op, 1'b0);
        sck_tog(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) sck_tog(a[31-8*i -: 8], 1'b0);
    endtask

    task automatic lat_edges();
        for (int i = 0; i < 2*LAT-1; i++) sck_tog(8'hEE, 1'b0);
    endtask

    task automatic ce_end();
        clks(Q);
        ce = 1'b1;
        clks(Q);
        sck = 1'b0; dqs_in = 1'b0;
        clks(2*Q);
    endtask

    task automatic psram_write(input logic [31:0] a, input int n,
                               input logic [3:0][7:0] d, input logic [3:0] m);
        logic [7:0] adr;
        hdr(8'h80, a);
        lat_edges();
        for (int i = 0; i < n; i++) begin
            sck_tog(d[i], m[i]);
            adr = (a[7:0] & 8'hFE) + 8'(i);
            if (!m[i]) tb_mem[adr] = d[i];
        end
        ce_end();
    endtask

    // captures {dqs_en, dqs_out, io_en, io_out} at entry and after each data edge
    task automatic psram_read(input logic [31:0] a, input int n);
        hdr(8'h00, a);
        lat_edges();
        got_q.push_back({dqs_en, dqs_out, io_en, io_out});
        for (int i = 1; i < n; i++) begin
            sck_tog(8'h00, 1'b0);
            got_q.push_back({dqs_en, dqs_out, io_en, io_out});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clks(3);
        n_cmp++;
        if ({busy, err, io_en, dqs_en, dqs_out, io_out} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b err=%b io_en=%h dqs_en=%b dqs=%b io=%h, want all 0",
                     busy, err, io_en, dqs_en, dqs_out, io_out);
        end
        rst = 1'b0;
        clks(6);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_write_read();
        logic [17:0] g;
        logic [7:0]  e;
        psram_write(32'h0000_0010, 4, {8'hC3, 8'h3C, 8'h5A, 8'hA5}, 4'b0000);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        psram_read(32'h0000_0010, 4);
        for (int i = 0; i < 4; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e || g[15:8] !== 8'hFF || g[16] !== i[0] || g[17] !== 1'b1) begin
                n_bad++;
                $display("FAIL wr_rd[%0d]: got io=%h en=%h dqs=%b dqs_en=%b, want io=%h en=ff dqs=%b dqs_en=1",
                         i, g[7:0], g[15:8], g[16], g[17], e, i[0]);
            end
        end
        ce_end();
    endtask

    task automatic test_odd_addr();
        logic [17:0] g;
        logic [7:0]  e;
        psram_write(32'h0000_0021, 2, {8'h00, 8'h00, 8'h22, 8'h11}, 4'b0000);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        psram_read(32'h0000_0020, 2);
        for (int i = 0; i < 2; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e || g[16] !== i[0]) begin
                n_bad++;
                $display("FAIL odd_addr[%0d]: got io=%h dqs=%b, want io=%h dqs=%b", i, g[7:0], g[16], e, i[0]);
            end
        end
        ce_end();
    endtask

    task automatic test_wrap();
        logic [17:0] g;
        logic [7:0]  e;
        psram_write(32'h0000_00FE, 4, {8'hD3, 8'hD2, 8'hD1, 8'hD0}, 4'b0000);
        for (int i = 0; i < 2; i++) exp_q.push_back(tb_mem[8'(i)]);
        psram_read(32'h0000_0000, 2);
        for (int i = 0; i < 2; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e) begin
                n_bad++;
                $display("FAIL wrap_low[%0d]: got %h want %h", i, g[7:0], e);
            end
        end
        ce_end();
        for (int i = 0; i < 4; i++) exp_q.push_back(tb_mem[8'hFE + 8'(i)]);
        psram_read(32'h0000_00FE, 4);
        for (int i = 0; i < 4; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e) begin
                n_bad++;
                $display("FAIL wrap_rd[%0d]: got %h want %h", i, g[7:0], e);
            end
        end
        ce_end();
    endtask

    task automatic test_mask();
        logic [17:0] g;
        logic [7:0]  e;
        psram_write(32'h0000_0040, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 4'b0000);
        psram_write(32'h0000_0040, 3, {8'h00, 8'hCC, 8'hBB, 8'hAA}, 4'b0010);
        for (int i = 0; i < 3; i++) exp_q.push_back(tb_mem[8'h40 + 8'(i)]);
        psram_read(32'h0000_0040, 3);
        for (int i = 0; i < 3; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e) begin
                n_bad++;
                $display("FAIL mask[%0d]: got %h want %h", i, g[7:0], e);
            end
        end
        ce_end();
    endtask

    task automatic test_bad_opcode();
        logic [17:0] g;
        logic [7:0]  e;
        hdr(8'h40, 32'h0000_0010);
        clks(2);
        n_cmp++;
        if ({err, busy, io_en} !== {1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL bad_op: got err=%b busy=%b io_en=%h, want err=1 busy=0 io_en=00", err, busy, io_en);
        end
        lat_edges();
        sck_tog(8'h00, 1'b0);
        n_cmp++;
        if ({busy, io_en, dqs_en} !== 10'h0) begin
            n_bad++;
            $display("FAIL bad_op_ignore: got busy=%b io_en=%h dqs_en=%b, want 0", busy, io_en, dqs_en);
        end
        ce_end();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        psram_read(32'h0000_0010, 4);
        for (int i = 0; i < 4; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e || g[15:8] !== 8'hFF) begin
                n_bad++;
                $display("FAIL bad_op_rd[%0d]: got io=%h en=%h, want io=%h en=ff", i, g[7:0], g[15:8], e);
            end
        end
        ce_end();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_abort_ce();
        logic [17:0] g;
        logic [7:0]  e;
        for (int i = 0; i < 3; i++) exp_q.push_back(tb_mem[8'h10 + 8'(i)]);
        psram_read(32'h0000_0010, 3);
        for (int i = 0; i < 3; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e) begin
                n_bad++;
                $display("FAIL abort_rd[%0d]: got %h want %h", i, g[7:0], e);
            end
        end
        ce = 1'b1;
        clks(4);
        n_cmp++;
        if ({busy, io_en, dqs_en} !== 10'h0) begin
            n_bad++;
            $display("FAIL abort_ce: got busy=%b io_en=%h dqs_en=%b, want 0", busy, io_en, dqs_en);
        end
        sck = 1'b0;
        clks(2*Q);
    endtask

    task automatic test_abort_rst();
        logic [17:0] g;
        logic [7:0]  e;
        hdr(8'h80, 32'h0000_0010);
        sck_tog(8'h99, 1'b0);
        sck_tog(8'h99, 1'b0);
        sck_tog(8'h99, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL latn_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        clks(1);
        n_cmp++;
        if ({busy, io_en, dqs_en, err} !== 11'h0) begin
            n_bad++;
            $display("FAIL abort_rst: got busy=%b io_en=%h dqs_en=%b err=%b, want 0", busy, io_en, dqs_en, err);
        end
        rst = 1'b0;
        ce  = 1'b1;
        clks(Q);
        sck = 1'b0;
        clks(2*Q);
        for (int i = 0; i < 4; i++) exp_q.push_back(tb_mem[8'h10 + 8'(i)]);
        psram_read(32'h0000_0010, 4);
        for (int i = 0; i < 4; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g[7:0] !== e) begin
                n_bad++;
                $display("FAIL mem_kept[%0d]: got %h want %h", i, g[7:0], e);
            end
        end
        ce_end();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_odd_addr();
        test_wrap();
        test_mask();
        test_bad_opcode();
        test_abort_ce();
        test_abort_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
